sram_responder: RTL
===================

# sram_responder

Synthesizable responder for the 16-bit asynchronous-SRAM pin interface driven by `cache_controller` and `SRAM_controller`: it samples the active-low SRAM control pins on `clk`, holds a word-addressed memory array, and drives `SRAM_DQ` back with programmable read and write latency. It replaces the board SRAM in simulation and in on-chip loopback builds, so the memory stage's stall/`ready` behaviour can be exercised deterministically. Debug outputs mirror the `SW`/`monitor_*` style used at the top level.

## Interface

Parameters:
- `DEPTH_W`, 8, implemented address bits; the array holds 2^DEPTH_W 16-bit words.
- `READ_LAT`, 2, cycles from accepted read to `SRAM_DQ` valid (1..15).
- `WRITE_LAT`, 2, cycles from accepted write to array commit (1..15).

Ports:
- `clk`  in  1  single clock; all sampling is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `SRAM_ADDR`  in  18  word address; bits above `DEPTH_W` are ignored (aliased).
- `SRAM_DQ`  inout  16  data bus; driven only in RD_DRIVE, otherwise Z.
- `SRAM_UB_N`  in  1  upper byte lane enable [15:8], active low.
- `SRAM_LB_N`  in  1  lower byte lane enable [7:0], active low.
- `SRAM_WE_N`  in  1  write enable, active low.
- `SRAM_CE_N`  in  1  chip enable, active low.
- `SRAM_OE_N`  in  1  output enable, active low.
- `busy`  out  1  high in RD_WAIT, WR_WAIT, WR_HOLD.
- `rd_count`  out  16  accepted reads, wraps at 16'hFFFF.
- `wr_count`  out  16  committed writes, wraps at 16'hFFFF.
- `mon_addr`  in  DEPTH_W  monitor address.
- `mon_data`  out  16  array[`mon_addr`], combinational.

## Operation

State machine: IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD.
- Write request: `CE_N=0 & WE_N=0`. WE has priority over OE regardless of `OE_N`.
- Read request: `CE_N=0 & WE_N=1 & OE_N=0`.
- IDLE:
  - On a write request, latch address, DQ and lanes, load counter with `WRITE_LAT-1`, go to WR_WAIT.
  - On a read request, latch address, load `READ_LAT-1`, go to RD_WAIT.
- WR_WAIT:
  - Count down. At 0, write the enabled lanes only (`UB_N`/`LB_N` latched at acceptance), increment `wr_count`, go to WR_HOLD.
  - If `CE_N` or `WE_N` goes high before commit, abort: no write, go to IDLE.
- WR_HOLD: stay until `WE_N=1` or `CE_N=1`, then IDLE. One WE pulse commits exactly one write.
- RD_WAIT:
  - Count down. At 0, increment `rd_count`, go to RD_DRIVE.
  - If the address changes, relatch it and reload the counter.
  - If the read request drops, go to IDLE.
- RD_DRIVE:
  - Drive the registered data on enabled lanes only; disabled lanes are Z.
  - Address change: go to RD_WAIT with the new address and reload.
  - `CE_N=1` or `OE_N=1`: go to IDLE.
  - `WE_N=0`: go to IDLE, then accept the write next cycle.
- Both lanes disabled: the access is still accepted and counted; a write changes nothing, a read drives all Z.

## Timing

- Reset (async): state IDLE, counter 0, `busy=0`, `rd_count=0`, `wr_count=0`, `SRAM_DQ` Z immediately. A pending write is discarded. Array contents are not reset.
- Read latency: request sampled at edge N, DQ valid after edge N+`READ_LAT`, held while the request is stable.
- Write commit at edge N+`WRITE_LAT`. A read of the same address accepted after commit returns the new data.
- DQ release: `OE_N`/`CE_N` high sampled at edge M, DQ Z after edge M. There is no combinational path from pins to DQ enable.
- `mon_data` reflects a commit in the cycle after the commit edge.

## Structure

- Shared package `sram_pkg`:
  - state encoding constants;
  - `SRAM_ADDR_W=18` and `SRAM_DATA_W=16`;
  - lane-mask helper constants.
- One sub-module, `sram_array`: 2^DEPTH_W x 16 storage with per-byte write enables, one registered read port and one asynchronous monitor port.
- The FSM, counters and tristate driver live in `sram_responder`.

## Test plan

- Default parameters: write 16'hBEEF to address 5 with both lanes, `WE_N` held low for 3 cycles -> `wr_count=1`; read address 5 -> DQ=16'hBEEF exactly 2 cycles after acceptance; `rd_count=1`.
- Byte lanes: address 5 holds 16'hBEEF; write 16'h1234 with `UB_N=1, LB_N=0` -> readback 16'hBE34. Read with `LB_N=1` -> DQ[7:0]=Z, DQ[15:8]=16'hBE.
- Write abort and single-commit:
  - `WE_N` low for 1 cycle (`WRITE_LAT=2`) -> no write, `wr_count` unchanged.
  - `WE_N` low for 10 cycles -> exactly one write.
- Address change in RD_DRIVE: switch 5 -> 6 (6 holds 16'h00AA) -> DQ shows address-5 data, then after 2 cycles 16'h00AA; `rd_count=2`. Aliasing: address 18'h00105 returns address-5 data.
- Reset mid-operation: assert `rst` in WR_WAIT -> DQ Z immediately, counters 0, old data at the target address unchanged; assert `rst` in RD_DRIVE -> DQ Z same cycle.
- WE/OE conflict: `CE_N=0, OE_N=0, WE_N=0` -> treated as a write, DQ never driven by the responder.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous-SRAM responder.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned LAT_W       = 4;

  localparam logic [SRAM_DATA_W-1:0] MASK_LO = 16'h00FF;
  localparam logic [SRAM_DATA_W-1:0] MASK_HI = 16'hFF00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DRIVE = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  // lanes[1] = upper byte, lanes[0] = lower byte (active high)
  function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [1:0] lanes);
    return (lanes[1] ? MASK_HI : '0) | (lanes[0] ? MASK_LO : '0);
  endfunction

endpackage

// File: rtl/sram_array.sv
// Word-addressed storage with byte-lane writes, a registered read port
// and an asynchronous monitor port.
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_W = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [1:0]             be,
  input  logic [DEPTH_W-1:0]     addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata,
  input  logic [DEPTH_W-1:0]     mon_addr,
  output logic [SRAM_DATA_W-1:0] mon_data
);

  localparam int unsigned WORDS = 1 << DEPTH_W;

  logic [SRAM_DATA_W-1:0] mem [WORDS];
  logic [SRAM_DATA_W-1:0] mask;

  assign mask = lane_mask(be);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
    end
    rdata <= mem[addr];
  end

  assign mon_data = mem[mon_addr];

endmodule

// File: rtl/sram_responder.sv
// Pin-level responder for a 16-bit async SRAM: samples the control pins on clk,
// stores into sram_array and returns read data with programmable latency.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 8,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  input  logic                   SRAM_UB_N,
  input  logic                   SRAM_LB_N,
  input  logic                   SRAM_WE_N,
  input  logic                   SRAM_CE_N,
  input  logic                   SRAM_OE_N,
  output logic                   busy,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count,
  input  logic [DEPTH_W-1:0]     mon_addr,
  output logic [15:0]            mon_data
);

  localparam logic [LAT_W-1:0] RD_RELOAD = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WR_RELOAD = LAT_W'(WRITE_LAT - 1);

  state_t                 state;
  logic [LAT_W-1:0]       cnt;
  logic [DEPTH_W-1:0]     addr_q;
  logic [DEPTH_W-1:0]     pin_addr;
  logic [SRAM_DATA_W-1:0] wdata_q;
  logic [SRAM_DATA_W-1:0] rdata;
  logic [1:0]             lanes_q;
  logic [1:0]             lanes_pin;
  logic [1:0]             drive_q;
  logic                   wr_req_c;
  logic                   rd_req_c;
  logic                   addr_chg_c;
  logic                   commit_c;

  // Upper address bits are aliased away
  generate
    if (DEPTH_W < SRAM_ADDR_W) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^SRAM_ADDR[SRAM_ADDR_W-1:DEPTH_W];
    end
  endgenerate

  assign pin_addr   = SRAM_ADDR[DEPTH_W-1:0];
  assign lanes_pin  = {~SRAM_UB_N, ~SRAM_LB_N};
  assign wr_req_c   = ~SRAM_CE_N & ~SRAM_WE_N;
  assign rd_req_c   = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
  assign addr_chg_c = (pin_addr != addr_q);
  // The array write lands on the same edge that the FSM leaves WR_WAIT
  assign commit_c   = (state == ST_WR_WAIT) && wr_req_c && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lanes_q  <= '0;
      drive_q  <= '0;
      busy     <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      drive_q <= '0;
      busy    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_req_c) begin
            addr_q  <= pin_addr;
            wdata_q <= SRAM_DQ;
            lanes_q <= lanes_pin;
            cnt     <= WR_RELOAD;
            state   <= ST_WR_WAIT;
            busy    <= 1'b1;
          end else if (rd_req_c) begin
            addr_q <= pin_addr;
            cnt    <= RD_RELOAD;
            state  <= ST_RD_WAIT;
            busy   <= 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (!wr_req_c) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            wr_count <= wr_count + 16'd1;
            state    <= ST_WR_HOLD;
            busy     <= 1'b1;
          end else begin
            cnt  <= cnt - LAT_W'(1);
            busy <= 1'b1;
          end
        end
        ST_WR_HOLD: begin
          if (!wr_req_c) state <= ST_IDLE;
          else           busy  <= 1'b1;
        end
        ST_RD_WAIT: begin
          if (!rd_req_c) begin
            state <= ST_IDLE;
          end else if (addr_chg_c) begin
            addr_q <= pin_addr;
            cnt    <= RD_RELOAD;
            busy   <= 1'b1;
          end else if (cnt == '0) begin
            rd_count <= rd_count + 16'd1;
            state    <= ST_RD_DRIVE;
            drive_q  <= lanes_pin;
          end else begin
            cnt  <= cnt - LAT_W'(1);
            busy <= 1'b1;
          end
        end
        ST_RD_DRIVE: begin
          // A dropped request covers CE/OE high and a WE pulse alike
          if (!rd_req_c) begin
            state <= ST_IDLE;
          end else if (addr_chg_c) begin
            addr_q <= pin_addr;
            cnt    <= RD_RELOAD;
            state  <= ST_RD_WAIT;
            busy   <= 1'b1;
          end else begin
            drive_q <= lanes_pin;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sram_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk      (clk),
    .we       (commit_c),
    .be       (lanes_q),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .rdata    (rdata),
    .mon_addr (mon_addr),
    .mon_data (mon_data)
  );

  // Drive enables come only from registers, so release follows the sampling edge
  assign SRAM_DQ[15:8] = drive_q[1] ? rdata[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = drive_q[0] ? rdata[7:0]  : 8'hzz;

endmodule
